// File: rtl/apb_mst_pkg.sv
// Shared constants for the simple APB initiator: bus widths, default timeout
// and FSM state encodings.
package apb_mst_pkg;

    localparam int unsigned APB_AW          = 32;
    localparam int unsigned APB_DW          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    function automatic logic [APB_AW-1:0] word_align(input logic [APB_AW-1:0] addr);
        return {addr[APB_AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/apb_mst_timeout.sv
// ACCESS-phase stall counter; flags expiry once the count reaches TIMEOUT.
// TIMEOUT of 0 disables expiry entirely.
module apb_mst_timeout
    import apb_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at the limit so a held stall can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == Limit);

endmodule

// File: rtl/apb_simple_master.sv
// Single-outstanding APB initiator: valid/ready request in, APB setup/access out,
// valid/ready response back with read data, slave error and stall timeout status.
module apb_simple_master
    import apb_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  prot_q, prot_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        to_q, to_d;

    logic accept;
    logic stall;
    logic expired;

    assign accept = (state_q == StIdle) && req_valid;
    assign stall  = (state_q == StAccess) && !pready;

    apb_mst_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (accept),
        .enable  (stall),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        prot_d  = prot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StSetup;
                    write_d = req_write;
                    addr_d  = word_align(req_addr);
                    wdata_d = req_wdata;
                    prot_d  = req_prot;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                // pready on the expiry edge still counts as a normal completion.
                if (pready) begin
                    state_d = StResp;
                    rdata_d = write_q ? 32'h0 : prdata;
                    err_d   = pslverr;
                    to_d    = 1'b0;
                end else if (expired) begin
                    state_d = StResp;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign psel        = (state_q == StSetup) || (state_q == StAccess);
    assign penable     = (state_q == StAccess);
    assign rsp_valid   = (state_q == StResp);
    assign pwrite      = write_q;
    assign paddr       = addr_q;
    assign pwdata      = wdata_q;
    assign pprot       = prot_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

endmodule
